// File: rtl/factorial_pkg.sv
// Shared types and default widths for the iterative factorial engine.
package factorial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_W_DEF = 8;
  localparam int R_W_DEF = 16;

endpackage

// File: rtl/fact_mul.sv
// Combinational N_W x R_W multiplier: low R_W product bits plus an overflow
// flag raised when any of the upper N_W product bits is set.
module fact_mul
  import factorial_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int R_W = R_W_DEF
) (
  input  logic [R_W-1:0] acc,
  input  logic [N_W-1:0] n,
  output logic [R_W-1:0] lo,
  output logic           ovf
);

  logic [N_W+R_W-1:0] product_s;

  // Form the full-width product, then split it into kept bits and overflow.
  always_comb begin
    product_s = {{N_W{1'b0}}, acc} * {{R_W{1'b0}}, n};
    lo        = product_s[R_W-1:0];
    ovf       = |product_s[N_W+R_W-1:R_W];
  end

endmodule

// File: rtl/factorial_engine.sv
// Iterative factorial engine: one multiply per clock, sticky overflow flag.
// Optional build macro FACTORIAL_SAT_EN saturates Result to all-ones on overflow.
module factorial_engine
  import factorial_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int R_W = R_W_DEF
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Start,
  input  logic [N_W-1:0] D_in,
  output logic           Busy,
  output logic           Done,
  output logic [R_W-1:0] Result,
  output logic           Ovf
);

  localparam logic [N_W-1:0] N_ONE = {{(N_W-1){1'b0}}, 1'b1};
  localparam logic [R_W-1:0] R_ONE = {{(R_W-1){1'b0}}, 1'b1};

  state_t         state_r;
  logic [N_W-1:0] n_r;
  logic [R_W-1:0] mul_lo_s;
  logic           mul_ovf_s;
  logic [R_W-1:0] next_res_s;

  fact_mul #(
    .N_W (N_W),
    .R_W (R_W)
  ) u_mul (
    .acc (Result),
    .n   (n_r),
    .lo  (mul_lo_s),
    .ovf (mul_ovf_s)
  );

  // Next accumulator value; the saturating build pins it once overflow is seen.
  always_comb begin
`ifdef FACTORIAL_SAT_EN
    if (Ovf || mul_ovf_s) begin
      next_res_s = {R_W{1'b1}};
    end else begin
      next_res_s = mul_lo_s;
    end
`else
    next_res_s = mul_lo_s;
`endif
  end

  // Control FSM with the operand down-counter and Result/Ovf registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
      n_r     <= {N_W{1'b0}};
      Result  <= {R_W{1'b0}};
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (Start) begin
            state_r <= MULT;
            n_r     <= D_in;
            Result  <= R_ONE;
            Ovf     <= 1'b0;
            Busy    <= 1'b1;
            Done    <= 1'b0;
          end else begin
            state_r <= state_r;
            Busy    <= 1'b0;
            Done    <= (state_r == DONE);
          end
        end
        MULT: begin
          // 0 and 1 skip the multiply entirely, so both yield 1.
          if (n_r > N_ONE) begin
            n_r    <= n_r - N_ONE;
            Result <= next_res_s;
            Ovf    <= Ovf | mul_ovf_s;
            Busy   <= 1'b1;
            Done   <= 1'b0;
          end else begin
            state_r <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/factorial_engine.md
Name: factorial_engine

Overview:
- Parametrised iterative factorial unit: accepts an N_W-bit operand on a Start handshake and computes D_in! into an R_W-bit result, one multiply per clock.
- Single FSM plus datapath in one block, with no external control/datapath split.
- Adds reset, Busy/Done handshake, correct 0!/1! handling and sticky overflow detection.
- Used as a standalone arithmetic engine behind a register interface or testbench driver.

Parameters:
- N_W, 8, operand width (max computable n = 2^N_W - 1)
- R_W, 16, result register width; must satisfy R_W >= N_W

Ports:
- Clk  input  1  clock; all state updates on the rising edge only
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE or DONE state
- D_in  input  N_W  operand n, captured on the accepting edge
- Busy  output  1  high while a computation is in progress (state MULT)
- Done  output  1  high while in DONE; Result is valid and stable
- Result  output  R_W  factorial result (low R_W bits, or saturated, see Optional Feature)
- Ovf  output  1  sticky: the true n! did not fit in R_W bits

Behaviour:
- Reset: the FSM is synchronous, active-high. On a Rst edge: state=IDLE, N=0, Result=0, Busy=0, Done=0, Ovf=0. Rst has priority over every other input, including mid-computation; a partial result is discarded.
- States:
  - IDLE: entered only after reset.
  - MULT: computing.
  - DONE: result held.
- IDLE/DONE, Start=1: on the edge, N<=D_in, Result<=1, Ovf<=0, state<=MULT. Start=0: hold; in DONE, Result, Ovf and Done stay stable indefinitely.
- MULT, N>1: on the edge, Result<=Result*N (product formed at N_W+R_W bits), N<=N-1, and stay in MULT.
- MULT, N<=1: on the edge, state<=DONE. No multiply is performed, so 0! = 1! = 1.
- Start in MULT: ignored; no queueing.
- Latency: for operand n, Done rises after the edge max(n,1) edges after the accepting edge. Examples: n=5 gives Done 5 cycles after acceptance; n=0 gives 1 cycle.
- Busy = (state==MULT); Done = (state==DONE). Both are registered state decodes and mutually exclusive.
- Overflow:
  - If the upper N_W bits of any full product are nonzero, Ovf<=1 on that edge.
  - Ovf stays set until the next accepted Start or Rst.
  - Computation continues to completion regardless; latency is unchanged by overflow.
- Back-to-back: Start held high in DONE launches the next computation on the next edge, so Done is low for at least max(n,1) cycles.

Optional Feature:
- FACTORIAL_SAT_EN defined: once Ovf is set (including on the overflowing edge itself), Result<={R_W{1'b1}} and holds that value through the remaining MULT cycles and DONE.
- FACTORIAL_SAT_EN undefined: Result carries the low R_W bits of the true product (n! mod 2^R_W); Ovf is still reported.
- Latency is identical in both builds.

Decomposition:
- Package factorial_pkg:
  - state typedef with encodings IDLE=2'd0, MULT=2'd1, DONE=2'd2
  - default N_W/R_W constants
- One combinational sub-module, fact_mul (N_W x R_W multiplier). Outputs the low R_W bits and an overflow bit (OR of the upper N_W bits).
- The FSM, the N down-counter and the Result/Ovf registers live in factorial_engine.

Test Plan (N_W=8, R_W=16):
- Reset, then D_in=5 with one-cycle Start -> Busy high for 5 cycles; Done=1, Result=120 (0x0078), Ovf=0.
- D_in=0, then separately D_in=1 -> each gives Done 1 cycle after acceptance with Result=1, Ovf=0.
- D_in=8 -> Result=40320 (0x9D80), Ovf=0. D_in=9 -> Ovf=1; Result=0x8980 without FACTORIAL_SAT_EN, 0xFFFF with it.
- Start with D_in=5, then Start with D_in=3 pulsed 2 cycles later during Busy -> ignored; final Result=120. A new Start in DONE with D_in=3 -> Ovf cleared, Result=6.
- Start with D_in=7, assert Rst in cycle 3 of MULT -> next edge gives Busy=0, Done=0, Result=0, Ovf=0, state IDLE. A subsequent D_in=4 gives Result=24.
- After a D_in=9 overflow, Start with D_in=4 -> Ovf=0, Result=24 (sticky flag cleared on acceptance).
